// File: rtl/vga_scan_pkg.sv
// Shared constants for the VGA scan-out path: 640x480@60 timing and buffer geometry.
package vga_scan_pkg;

  // Buffer geometry defaults (160x120, one RGB bit per channel)
  localparam int XSCREEN_DEF  = 160;
  localparam int YSCREEN_DEF  = 120;
  localparam int COLOUR_W_DEF = 3;
  localparam int ADDR_W_DEF   = 15;

  // Width of the pixel/line counters
  localparam int CNT_W = 10;

  // Horizontal timing, in pixel clocks
  localparam logic [CNT_W-1:0] H_VISIBLE    = 10'd640;
  localparam logic [CNT_W-1:0] H_FP         = 10'd16;
  localparam logic [CNT_W-1:0] H_SYNC       = 10'd96;
  localparam logic [CNT_W-1:0] H_BP         = 10'd48;
  localparam logic [CNT_W-1:0] H_TOTAL      = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam logic [CNT_W-1:0] H_LAST       = H_TOTAL - 10'd1;
  localparam logic [CNT_W-1:0] H_SYNC_START = H_VISIBLE + H_FP;
  localparam logic [CNT_W-1:0] H_SYNC_END   = H_SYNC_START + H_SYNC;

  // Vertical timing, in lines
  localparam logic [CNT_W-1:0] V_VISIBLE    = 10'd480;
  localparam logic [CNT_W-1:0] V_FP         = 10'd10;
  localparam logic [CNT_W-1:0] V_SYNC       = 10'd2;
  localparam logic [CNT_W-1:0] V_BP         = 10'd33;
  localparam logic [CNT_W-1:0] V_TOTAL      = V_VISIBLE + V_FP + V_SYNC + V_BP;
  localparam logic [CNT_W-1:0] V_LAST       = V_TOTAL - 10'd1;
  localparam logic [CNT_W-1:0] V_SYNC_START = V_VISIBLE + V_FP;
  localparam logic [CNT_W-1:0] V_SYNC_END   = V_SYNC_START + V_SYNC;

  // Fold a scrolled row back into 0..modulus-1; the sum never reaches twice the modulus
  function automatic logic [7:0] wrap_row(input logic [7:0] row, input logic [7:0] modulus);
    return (row >= modulus) ? (row - modulus) : row;
  endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// 640x480@60 raster timing: 25 MHz pixel enable from a 50 MHz clock,
// horizontal/vertical counters, region decode and the DAC clock.
module vga_timing_gen
  import vga_scan_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  output logic             pix_en,
  output logic [CNT_W-1:0] h_count,
  output logic [CNT_W-1:0] v_count,
  output logic             visible,
  output logic             hs,
  output logic             vs,
  output logic             frame_start,
  output logic             vga_clk
);

  logic phase;

  assign pix_en = phase;

  // Phase toggles every clock; raster counters step once per pixel enable
  always_ff @(posedge clk) begin
    if (reset) begin
      phase   <= 1'b0;
      vga_clk <= 1'b0;
      h_count <= '0;
      v_count <= '0;
    end else begin
      phase   <= ~phase;
      vga_clk <= ~phase;
      if (pix_en) begin
        if (h_count == H_LAST) begin
          h_count <= '0;
          if (v_count == V_LAST) begin
            v_count <= '0;
          end else begin
            v_count <= v_count + 10'd1;
          end
        end else begin
          h_count <= h_count + 10'd1;
        end
      end
    end
  end

  // Decode visible region, active-low syncs and the first clock of vertical front porch
  always_comb begin
    visible     = (h_count < H_VISIBLE) && (v_count < V_VISIBLE);
    hs          = !((h_count >= H_SYNC_START) && (h_count < H_SYNC_END));
    vs          = !((v_count >= V_SYNC_START) && (v_count < V_SYNC_END));
    frame_start = pix_en && (h_count == 10'd0) && (v_count == V_VISIBLE);
  end

endmodule

// File: rtl/vga_scanout_reader.sv
// Scans the 160x120 frame buffer as 4x4 blocks on a 640x480 raster, applying a
// per-frame vertical scroll at read time, and drives the VGA DAC.
//
// Read port: rd_en is a one-clock strobe issued with rd_addr; there is no
// back-pressure. The buffer returns rd_data on the clock after the strobe and
// must hold it until the next strobe; it is consumed on the following pixel
// enable. rd_addr holds its last value between strobes.
module vga_scanout_reader
  import vga_scan_pkg::*;
#(
  parameter int XSCREEN  = XSCREEN_DEF,
  parameter int YSCREEN  = YSCREEN_DEF,
  parameter int COLOUR_W = COLOUR_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF
) (
  input  logic                CLOCK_50,
  input  logic                reset,
  input  logic [6:0]          scroll_offset,
  output logic [ADDR_W-1:0]   rd_addr,
  output logic                rd_en,
  input  logic [COLOUR_W-1:0] rd_data,
  output logic                frame_start,
  output logic [7:0]          VGA_R,
  output logic [7:0]          VGA_G,
  output logic [7:0]          VGA_B,
  output logic                VGA_HS,
  output logic                VGA_VS,
  output logic                VGA_BLANK_N,
  output logic                VGA_SYNC_N,
  output logic                VGA_CLK
);

  logic             pix_en;
  logic [CNT_W-1:0] h_count;
  logic [CNT_W-1:0] v_count;
  logic             visible;
  logic             hs_raw;
  logic             vs_raw;

  logic [6:0]        offset_q;
  logic [7:0]        x_fb;
  logic [7:0]        y_sum;
  logic [7:0]        y_fb;
  logic [ADDR_W-1:0] addr_next;

  // Stage-1 companions of the read, carried to the pins with the returned data
  logic s1_visible;
  logic s1_hs;
  logic s1_vs;

  vga_timing_gen u_timing (
    .clk         (CLOCK_50),
    .reset       (reset),
    .pix_en      (pix_en),
    .h_count     (h_count),
    .v_count     (v_count),
    .visible     (visible),
    .hs          (hs_raw),
    .vs          (vs_raw),
    .frame_start (frame_start),
    .vga_clk     (VGA_CLK)
  );

  assign VGA_SYNC_N = 1'b0;

  // Map the raster position to a buffer word, wrapping the scrolled row into the buffer height
  always_comb begin
    x_fb      = 8'(h_count >> 2);
    y_sum     = 8'(v_count >> 2) + {1'b0, offset_q};
    y_fb      = wrap_row(y_sum, 8'(YSCREEN));
    addr_next = ADDR_W'(y_fb) * ADDR_W'(XSCREEN) + ADDR_W'(x_fb);
  end

  // Capture the scroll offset once per frame so a frame never tears mid-scan
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      offset_q <= '0;
    end else if (frame_start) begin
      offset_q <= (scroll_offset >= 7'(YSCREEN)) ? 7'd0 : scroll_offset;
    end
  end

  // Stage 1: issue the buffer read and register sync/blank alongside it
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      rd_en      <= 1'b0;
      rd_addr    <= '0;
      s1_visible <= 1'b0;
      s1_hs      <= 1'b1;
      s1_vs      <= 1'b1;
    end else if (pix_en) begin
      rd_en      <= visible;
      if (visible) begin
        rd_addr <= addr_next;
      end
      s1_visible <= visible;
      s1_hs      <= hs_raw;
      s1_vs      <= vs_raw;
    end else begin
      rd_en <= 1'b0;
    end
  end

  // Stage 2: expand the returned word to 8-bit channels and drive the DAC pins together
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      VGA_R       <= 8'h00;
      VGA_G       <= 8'h00;
      VGA_B       <= 8'h00;
      VGA_HS      <= 1'b1;
      VGA_VS      <= 1'b1;
      VGA_BLANK_N <= 1'b0;
    end else if (pix_en) begin
      VGA_R       <= s1_visible ? {8{rd_data[2]}} : 8'h00;
      VGA_G       <= s1_visible ? {8{rd_data[1]}} : 8'h00;
      VGA_B       <= s1_visible ? {8{rd_data[0]}} : 8'h00;
      VGA_HS      <= s1_hs;
      VGA_VS      <= s1_vs;
      VGA_BLANK_N <= s1_visible;
    end
  end

endmodule

// File: tb/tb_vga_scanout_reader.sv
// Bench for vga_scanout_reader: a buffer model answers reads, and a raster
// model derived from elapsed clocks predicts every output on every clock.
module tb_vga_scanout_reader;

  localparam int NPIX      = 19200;
  localparam int FRAME_PIX = 420000;

  logic        CLOCK_50;
  logic        reset;
  logic [6:0]  scroll_offset;
  logic [14:0] rd_addr;
  logic        rd_en;
  logic [2:0]  rd_data;
  logic        frame_start;
  logic [7:0]  VGA_R;
  logic [7:0]  VGA_G;
  logic [7:0]  VGA_B;
  logic        VGA_HS;
  logic        VGA_VS;
  logic        VGA_BLANK_N;
  logic        VGA_SYNC_N;
  logic        VGA_CLK;

  vga_scanout_reader dut (
    .CLOCK_50      (CLOCK_50),
    .reset         (reset),
    .scroll_offset (scroll_offset),
    .rd_addr       (rd_addr),
    .rd_en         (rd_en),
    .rd_data       (rd_data),
    .frame_start   (frame_start),
    .VGA_R         (VGA_R),
    .VGA_G         (VGA_G),
    .VGA_B         (VGA_B),
    .VGA_HS        (VGA_HS),
    .VGA_VS        (VGA_VS),
    .VGA_BLANK_N   (VGA_BLANK_N),
    .VGA_SYNC_N    (VGA_SYNC_N),
    .VGA_CLK       (VGA_CLK)
  );

  // Clock: 50 MHz
  initial begin
    CLOCK_50 = 1'b0;
    forever #10 CLOCK_50 = ~CLOCK_50;
  end

  // Frame buffer: word returned on the clock after a read strobe, then held
  logic [2:0] mem [0:NPIX-1];
  always @(posedge CLOCK_50) begin
    if (rd_en) rd_data <= mem[rd_addr];
  end

  // Scoreboard state
  int          cmp_cnt = 0;
  int          mis_cnt = 0;
  int          t = 0;            // clocks since the scan (re)started
  int          last_addr = 0;    // address of the most recent visible read
  int          frame_off [0:7];  // scroll offset in force for each frame
  logic [26:0] exp_q [$];        // expected {HS,VS,BLANK_N,R,G,B} per pixel
  logic [26:0] pins_exp;
  logic [26:0] reset_pins;
  bit          mem_mod8;
  int          hs_low, vs_low, fs_cnt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    cmp_cnt++;
    assert (obs === exp) else begin
      mis_cnt++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h at clock %0d", tag, obs, exp, t);
    end
  endtask

  // One clock: advance the model at the edge, compare all outputs mid-cycle
  task automatic tick();
    int   k, h, v, f, y, j, jh, jv, jf;
    bit   vis;
    bit   exp_rd_en;
    bit   exp_fs;
    logic [2:0] w;
    exp_rd_en = 1'b0;
    exp_fs    = 1'b0;
    h = 0; v = 0; f = 0;
    @(posedge CLOCK_50);
    if (reset) begin
      t = 0;
      last_addr = 0;
      exp_q.delete();
      pins_exp = reset_pins;
      frame_off[0] = 0;
      hs_low = 0; vs_low = 0; fs_cnt = 0;
    end else begin
      t++;
      if (t % 2 == 0) begin
        // Pixel k of the raster is read at clock 2k+2
        k = t / 2 - 1;
        h = k % 800;
        v = (k / 800) % 525;
        f = k / FRAME_PIX;
        if (h == 0 && v == 480 && f < 7)
          frame_off[f + 1] = (scroll_offset >= 7'd120) ? 0 : int'(scroll_offset);
        vis = (h < 640) && (v < 480);
        if (vis) begin
          y = (v / 4 + frame_off[f]) % 120;
          last_addr = y * 160 + h / 4;
        end
        exp_rd_en = vis;
        w = vis ? mem[last_addr] : 3'b000;
        exp_q.push_back({(h < 656 || h >= 752), (v < 490 || v >= 492), vis,
                         {8{w[2]}}, {8{w[1]}}, {8{w[0]}}});
        if (t >= 4) pins_exp = exp_q.pop_front();
      end else begin
        k = (t - 1) / 2;
        exp_fs = (k % 800 == 0) && ((k / 800) % 525 == 480);
      end
    end
    @(negedge CLOCK_50);
    check("rd_en", rd_en, exp_rd_en);
    check("rd_addr", rd_addr, last_addr);
    check("addr_range", rd_addr < 15'd19200, 1);
    check("pins", {VGA_HS, VGA_VS, VGA_BLANK_N, VGA_R, VGA_G, VGA_B}, pins_exp);
    check("frame_start", frame_start, exp_fs);
    check("vga_clk_sync_n", {VGA_CLK, VGA_SYNC_N}, {(t % 2 == 1), 1'b0});
    if (t == 1) check("rd_en_clk1", rd_en, 0);
    if (t == 2) begin
      check("first_rd_en", rd_en, 1);
      check("first_rd_addr", rd_addr, 0);
    end
    if (t > 0 && t % 2 == 0) begin
      if (f == 1 && v == 4   && h < 64) check("off119_v4",    rd_addr, h / 4);
      if (f == 1 && v == 0   && h < 64) check("off119_v0",    rd_addr, 19040 + h / 4);
      if (f == 1 && v == 201 && h < 64) check("midframe_keep", rd_addr, 7840 + h / 4);
      if (f == 2 && v == 0   && h < 64) check("off30_v0",     rd_addr, 4800 + h / 4);
      if (f == 3 && v == 0   && h < 64) check("off125_v0",    rd_addr, h / 4);
      if (t >= 4) begin
        j  = t / 2 - 2;
        jh = j % 800;
        jv = (j / 800) % 525;
        jf = j / FRAME_PIX;
        if (mem_mod8 && jf == 0 && jh >= 8 && jh <= 11 && jv >= 4 && jv <= 7)
          check("block_8_4_rgb", {VGA_R, VGA_G, VGA_B}, 24'h00FF00);
      end
    end
    if (t >= 1 && t <= 2 * FRAME_PIX) begin
      hs_low = hs_low + int'(!VGA_HS);
      vs_low = vs_low + int'(!VGA_VS);
      fs_cnt = fs_cnt + int'(frame_start);
    end
    if (t == 2 * FRAME_PIX) begin
      check("hs_low_clocks_per_frame", hs_low, 100800);
      check("vs_low_clocks_per_frame", vs_low, 3200);
      check("frame_start_per_frame", fs_cnt, 1);
    end
  endtask

  // Run until the model's read position reaches (frame f, h, v)
  task automatic run_to(input int f, input int h, input int v);
    int target;
    target = 2 * (f * FRAME_PIX + v * 800 + h) + 2;
    for (int i = 0; i < 1000000 && t < target; i++) tick();
    check("run_to_position", t, target);
  endtask

  task automatic check_reset_pins(input string tag);
    check({tag, "_hs"},      VGA_HS, 1);
    check({tag, "_vs"},      VGA_VS, 1);
    check({tag, "_blank_n"}, VGA_BLANK_N, 0);
    check({tag, "_rd_en"},   rd_en, 0);
    check({tag, "_rd_addr"}, rd_addr, 0);
    check({tag, "_rgb"},     {VGA_R, VGA_G, VGA_B}, 0);
    check({tag, "_fs"},      frame_start, 0);
    check({tag, "_vga_clk"}, VGA_CLK, 0);
  endtask

  // Directed sequence
  initial begin
    reset_pins = {1'b1, 1'b1, 1'b0, 24'h000000};
    pins_exp   = reset_pins;
    for (int i = 0; i < 8; i++) frame_off[i] = 0;
    reset         = 1'b1;
    scroll_offset = 7'd0;
    mem_mod8      = 1'b1;
    for (int a = 0; a < NPIX; a++) mem[a] = 3'(a % 8);

    // Reset held for three clocks
    repeat (3) tick();
    check_reset_pins("init_reset");
    reset = 1'b0;

    // Scan part of a frame, then pulse reset mid-line
    run_to(0, 300, 250);
    reset = 1'b1;
    tick();
    check_reset_pins("mid_reset");
    reset = 1'b0;

    // Frame 0 scans with offset 0 while 119 waits to be latched
    scroll_offset = 7'd119;
    run_to(0, 0, 500);
    for (int a = 0; a < NPIX; a++) mem[a] = 3'($urandom_range(0, 7));
    mem_mod8 = 1'b0;

    // Frame 1 uses 119; input moves 5 -> 30 mid-frame, frame 1 keeps 119
    run_to(1, 0, 10);
    scroll_offset = 7'd5;
    run_to(1, 0, 200);
    scroll_offset = 7'd30;

    // Frame 2 uses 30; an out-of-range request must latch as 0 for frame 3
    run_to(2, 0, 100);
    scroll_offset = 7'd125;
    run_to(3, 0, 8);
    repeat (6) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, mis_cnt);
    $finish;
  end

endmodule
